tmds_rx_channel: RTL
====================

# tmds_rx_channel

Receive-side counterpart of the HDMI transmit clocking path: recovers one TMDS channel from a 5x-pixel-rate bit clock (125 MHz for 25 MHz pixels) carrying two serial bits per cycle from a DDR input cell. It assembles 10-bit symbols, finds symbol alignment by bit-slipping until control tokens line up, and decodes TMDS into 8-bit data or 2-bit control with a data-enable flag. Three instances, one per TMDS channel, sit between the DDR input pins and the pixel/sync recovery logic.

## Interface

- `SEARCH_WORDS`, 1024: words examined at one slip offset before advancing the slip.
- `LOCK_TOKENS`, 8: consecutive control-token words required to declare lock.
- `LOSS_WORDS`, 4096: words without any control token, while locked, before dropping lock.
- `clk`  in  1  5x pixel bit clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `din`  in  2  serial bits for this cycle; `din[0]` arrived earlier than `din[1]`.
- `valid`  out  1  one-cycle strobe, one per decoded symbol.
- `de`  out  1  1 = data symbol, 0 = control token.
- `data`  out  8  decoded byte; 0 when `de`=0.
- `ctrl`  out  2  decoded control bits; held from last token when `de`=1.
- `locked`  out  1  symbol alignment established.
- `slip`  out  4  current bit offset, 0..9.

## Operation

- History register `sr[19:0]`: every cycle `sr <= {din[1], din[0], sr[19:2]}`; bit 0 is oldest.
- Phase counter 0..4 free-runs from reset; a word is captured when phase = 4: `word = sr[slip+9 : slip]`, `word[0]` = first transmitted bit.
- Token detect (10-bit compare): 0x354 -> ctrl 00, 0x0AB -> 01, 0x154 -> 10, 0x2AB -> 11. Any other word is data.
- Data decode: `q = word[9] ? ~word[7:0] : word[7:0]`; `data[0] = q[0]`; for i=1..7, `data[i] = word[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1])`.
- FSM states SEARCH (reset state) and LOCKED.
- SEARCH: per captured word, token increments run counter (saturating), non-token clears it. Run counter reaching `LOCK_TOKENS` -> LOCKED, word counter cleared. Else word counter increments; on reaching `SEARCH_WORDS`, `slip` advances (9 wraps to 0), word and run counters clear.
- LOCKED: `slip` frozen. Word counter clears on any token, increments otherwise; reaching `LOSS_WORDS` -> SEARCH with run/word counters cleared, `slip` advanced by one (wrap 9->0).
- Lock reached and search-timeout on the same word: lock wins, `slip` unchanged.
- Decoded outputs are produced in both states; consumers qualify with `locked`.
- Word counter widths sized by `$clog2` of the larger of `SEARCH_WORDS`, `LOSS_WORDS`, plus one.

## Timing

- Reset: `valid`=0, `de`=0, `data`=0, `ctrl`=0, `locked`=0, `slip`=0, phase=0, `sr`=0, state SEARCH, all counters 0. Reset mid-word discards the partial word; first capture is 5 cycles after reset release.
- `valid` high exactly 1 cycle in 5, the cycle after capture; `de`/`data`/`ctrl` registered and stable from that cycle until the next strobe.
- Latency: a bit entering `din` appears in a decoded output 6..15 cycles later depending on position and `slip`.
- `locked` rises in the same cycle as the `valid` of the `LOCK_TOKENS`-th consecutive token; falls with the `valid` of the `LOSS_WORDS`-th token-free word.
- A new `slip` applies at the next capture; no symbols are dropped or duplicated by a slip (always exactly one `valid` per 5 cycles).

## Test plan

- Reset then idle stream of 0x354 tokens at true offset 0 -> 8th `valid` asserts `locked`=1, `de`=0, `ctrl`=00, `slip`=0.
- Token stream shifted by 3 bits -> `slip` steps 0,1,2,3 at 1024-word intervals; `locked` asserts 8 words after `slip`=3; each token decodes to correct `ctrl`.
- Locked, send data symbols 0x1FF-form encodings of bytes 0x00, 0xFF, 0xA5, 0x10 (encoded per TMDS) -> `de`=1 and `data` equals each byte, `ctrl` holds last token value.
- Locked, 4096 data words with no token -> `locked` drops on 4096th `valid`, `slip` increments by one; 4095 words then a token -> stays locked.
- Offset 9 search from `slip`=9 timeout -> `slip` wraps to 0.
- Assert `reset` mid-stream while locked -> all outputs 0 next cycle asynchronously, `valid` silent for 5 cycles after release, relock behaves as first scenario.

Source files
------------

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: builds 10-bit symbols from a 2-bit/cycle DDR stream, bit-slips to token alignment, decodes.
// One decoded-symbol strobe every 5 bit-clock cycles; no backpressure, consumers qualify outputs with locked.
module tmds_rx_channel #(
    parameter int SEARCH_WORDS = 1024,
    parameter int LOCK_TOKENS  = 8,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] din,
    output logic       valid,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] slip
);
    localparam int MAX_WORDS = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam int RW = $clog2(LOCK_TOKENS) + 1;
    localparam logic [CW-1:0] SEARCH_LIM = CW'(SEARCH_WORDS);
    localparam logic [CW-1:0] LOSS_LIM   = CW'(LOSS_WORDS);
    localparam logic [RW-1:0] LOCK_LIM   = RW'(LOCK_TOKENS);

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    state_t        state, state_nxt;
    logic [19:0]   sr;
    logic [2:0]    phase;
    logic          cap;
    logic [9:0]    word;
    logic          is_tok;
    logic [1:0]    tok_ctrl;
    logic [7:0]    q, dec;
    logic [RW-1:0] run, run_nxt, run_inc;
    logic [CW-1:0] wc, wc_nxt, wc_inc;
    logic [3:0]    slip_nxt, slip_adv;

    assign cap  = (phase == 3'd4);
    assign word = 10'(sr >> slip);

    always_comb begin
        is_tok   = 1'b1;
        tok_ctrl = 2'b00;
        case (word)
            10'h354: tok_ctrl = 2'b00;
            10'h0AB: tok_ctrl = 2'b01;
            10'h154: tok_ctrl = 2'b10;
            10'h2AB: tok_ctrl = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // word[9] undoes the transmit-side inversion, word[8] selects XOR vs XNOR chaining
    always_comb begin
        q      = word[9] ? ~word[7:0] : word[7:0];
        dec    = '0;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++)
            dec[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr    <= '0;
            phase <= '0;
            valid <= 1'b0;
            de    <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else begin
            sr    <= {din[1], din[0], sr[19:2]};
            phase <= cap ? 3'd0 : phase + 3'd1;
            valid <= cap;
            if (cap) begin
                de   <= ~is_tok;
                data <= is_tok ? 8'd0 : dec;
                if (is_tok)
                    ctrl <= tok_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_SEARCH;
            run   <= '0;
            wc    <= '0;
            slip  <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            wc    <= wc_nxt;
            slip  <= slip_nxt;
        end
    end

    always_comb begin
        run_inc   = is_tok ? ((run == LOCK_LIM) ? run : run + RW'(1)) : '0;
        wc_inc    = wc + CW'(1);
        slip_adv  = (slip == 4'd9) ? 4'd0 : slip + 4'd1;
        state_nxt = state;
        run_nxt   = run;
        wc_nxt    = wc;
        slip_nxt  = slip;
        if (cap) begin
            case (state)
                S_SEARCH: begin
                    run_nxt = run_inc;
                    // lock takes priority over a search timeout on the same word
                    if (run_inc == LOCK_LIM) begin
                        state_nxt = S_LOCKED;
                        wc_nxt    = '0;
                    end else if (wc_inc == SEARCH_LIM) begin
                        slip_nxt = slip_adv;
                        wc_nxt   = '0;
                        run_nxt  = '0;
                    end else begin
                        wc_nxt = wc_inc;
                    end
                end
                default: begin
                    if (is_tok) begin
                        wc_nxt = '0;
                    end else if (wc_inc == LOSS_LIM) begin
                        state_nxt = S_SEARCH;
                        slip_nxt  = slip_adv;
                        wc_nxt    = '0;
                        run_nxt   = '0;
                    end else begin
                        wc_nxt = wc_inc;
                    end
                end
            endcase
        end
    end

    always_comb begin
        locked = (state == S_LOCKED);
    end
endmodule
